shift_register_controller: RTL and testbench

Command-driven control stage that sits directly upstream of the WIDTH-bit universal shift register built from one-bit shift-register cells. It accepts load/shift/rotate commands over a valid/ready handshake and sequences each cell's 2-bit mux select, parallel-load data and serial fill bits cycle by cycle. It reports completion with a one-cycle done pulse.

---
 rtl/shift_register_controller_if.sv | 29 ++
 rtl/shift_register_controller.sv | 96 +++++++++
 tb/tb_shift_register_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/shift_register_controller_if.sv
// Command and cell-control bundle between a command source and the shift register controller.
interface shift_register_controller_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CW-1:0]    cmd_count;
    logic             cmd_fill;
    logic [WIDTH-1:0] q;
    logic [1:0]       sel;
    logic [WIDTH-1:0] par_in;
    logic             ser_right;
    logic             ser_left;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill, q,
        input  cmd_ready, sel, par_in, ser_right, ser_left, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill, q,
        output cmd_ready, sel, par_in, ser_right, ser_left, busy, done
    );
endinterface

// File: rtl/shift_register_controller.sv
// Sequences the per-cell mux select, parallel data and serial fill bits of a
// universal shift register for load / shift / rotate commands.
module shift_register_controller #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    shift_register_controller_if.slave    bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    logic [1:0]       state;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic             fill_r;
    logic [CW-1:0]    remaining;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_r      <= '0;
            data_r    <= '0;
            fill_r    <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_r   <= bus.cmd_op;
                        data_r <= bus.cmd_data;
                        fill_r <= bus.cmd_fill;
                        if (bus.cmd_op == OP_LOAD) begin
                            state <= LOAD;
                        end else if (bus.cmd_count != '0) begin
                            state     <= SHIFT;
                            remaining <= bus.cmd_count;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                LOAD:  state <= DONE;
                SHIFT: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == CW'(1)) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs depend only on state and latched fields, except the rotate feedback from q[0].
    always_comb begin
        bus.sel       = 2'b00;
        bus.par_in    = '0;
        bus.ser_right = 1'b0;
        bus.ser_left  = 1'b0;
        case (state)
            LOAD: begin
                bus.sel    = 2'b11;
                bus.par_in = data_r;
            end
            SHIFT: begin
                case (op_r)
                    OP_SHL: begin
                        bus.sel      = 2'b10;
                        bus.ser_left = fill_r;
                    end
                    OP_ROR: begin
                        bus.sel       = 2'b01;
                        bus.ser_right = bus.q[0];
                    end
                    default: begin
                        bus.sel       = 2'b01;
                        bus.ser_right = fill_r;
                    end
                endcase
            end
            default: ;
        endcase
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.cmd_ready = (state == IDLE) && !reset;

endmodule

// File: tb/tb_shift_register_controller.sv
// Bench for shift_register_controller driving a behavioural 8-bit universal shift register.
module tb_shift_register_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    shift_register_controller_if #(.WIDTH(8), .CW(4)) bus ();

    shift_register_controller #(.WIDTH(8), .CW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Downstream register: cell i takes q[i+1] / q[i-1] from neighbours, edge cells take the serial bits.
    logic [7:0] qreg = 8'h00;
    assign bus.q = qreg;
    always @(posedge clk) begin
        case (bus.sel)
            2'b01:   qreg <= {bus.ser_right, qreg[7:1]};
            2'b10:   qreg <= {qreg[6:0], bus.ser_left};
            2'b11:   qreg <= bus.par_in;
            default: qreg <= qreg;
        endcase
    end

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [3:0] count;
        logic       fill;
        logic [7:0] exp_q;
        logic [1:0] exp_sel;
        int         exp_sel_cycles;
        int         exp_done_at;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int sel_cyc, bad, done_at, done_cnt, waitc;
        waitc = 0;
        while (bus.cmd_ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        bus.cmd_op    = v.op;
        bus.cmd_data  = v.data;
        bus.cmd_count = v.count;
        bus.cmd_fill  = v.fill;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        sel_cyc = 0; bad = 0; done_at = 0; done_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.sel != 2'b00) begin
                sel_cyc++;
                if (bus.sel !== v.exp_sel) bad++;
            end
            if (bus.sel == 2'b01 && bus.ser_left !== 1'b0) bad++;
            if (bus.sel == 2'b10 && bus.ser_right !== 1'b0) bad++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (done_at != 0 && k == done_at + 1) break;
        end
        check($sformatf("v%0d done_cycle", idx), done_at, v.exp_done_at);
        check($sformatf("v%0d done_width", idx), done_cnt, 1);
        check($sformatf("v%0d sel_cycles", idx), sel_cyc, v.exp_sel_cycles);
        check($sformatf("v%0d sel_value", idx), bad, 0);
        check($sformatf("v%0d q", idx), bus.q, v.exp_q);
        check($sformatf("v%0d idle_after", idx), {bus.cmd_ready, bus.busy}, 2'b10);
    endtask

    initial begin
        int dcnt;
        vec_t v;
        //            op     data   cnt  fill exp_q  sel   selc done
        vecs[0] = '{2'b00, 8'hA5, 4'd0,  1'b0, 8'hA5, 2'b11, 1,  2};
        vecs[1] = '{2'b01, 8'h00, 4'd3,  1'b1, 8'hF4, 2'b01, 3,  4};
        vecs[2] = '{2'b00, 8'hA5, 4'd0,  1'b0, 8'hA5, 2'b11, 1,  2};
        vecs[3] = '{2'b10, 8'hFF, 4'd2,  1'b0, 8'h94, 2'b10, 2,  3};
        vecs[4] = '{2'b00, 8'h81, 4'd0,  1'b0, 8'h81, 2'b11, 1,  2};
        vecs[5] = '{2'b11, 8'h00, 4'd9,  1'b0, 8'hC0, 2'b01, 9,  10};
        vecs[6] = '{2'b01, 8'h00, 4'd0,  1'b1, 8'hC0, 2'b01, 0,  1};
        vecs[7] = '{2'b00, 8'h00, 4'd0,  1'b0, 8'h00, 2'b11, 1,  2};
        vecs[8] = '{2'b01, 8'h00, 4'd15, 1'b1, 8'hFF, 2'b01, 15, 16};
        vecs[9] = '{2'b10, 8'h00, 4'd15, 1'b0, 8'h00, 2'b10, 15, 16};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 8'h00;
        bus.cmd_count = 4'd0;
        bus.cmd_fill  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {bus.sel, bus.par_in, bus.ser_right, bus.ser_left, bus.busy, bus.done},
              {2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;
        #1 check("ready_after_reset", bus.cmd_ready, 1'b1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset in the second cycle of a 5-step shift right from q=00, fill 1
        @(negedge clk);
        bus.cmd_op = 2'b01; bus.cmd_count = 4'd5; bus.cmd_fill = 1'b1; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("abort_outputs", {bus.sel, bus.busy, bus.done, bus.ser_right}, 5'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.done === 1'b1) dcnt++;
            @(negedge clk);
        end
        check("abort_no_done", dcnt, 0);
        check("abort_idle", {bus.cmd_ready, bus.busy}, 2'b10);
        check("abort_q_kept", bus.q, 8'h80);
        v = '{2'b00, 8'h3C, 4'd0, 1'b0, 8'h3C, 2'b11, 1, 2};
        run_vec(v, 10);

        // cmd_valid held high with data changing while busy
        @(negedge clk);
        bus.cmd_op = 2'b00; bus.cmd_data = 8'h11; bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_sel1", {bus.sel, bus.par_in}, {2'b11, 8'h11});
        bus.cmd_data = 8'h22;
        @(negedge clk);
        check("hold_done1", {bus.done, bus.q}, {1'b1, 8'h11});
        bus.cmd_data = 8'h33;
        @(negedge clk);
        check("hold_idle", {bus.cmd_ready, bus.busy, bus.done}, 3'b100);
        bus.cmd_data = 8'h44;
        @(negedge clk);
        check("hold_sel2", {bus.sel, bus.par_in}, {2'b11, 8'h44});
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("hold_done2", {bus.done, bus.q}, {1'b1, 8'h44});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
